// File: rtl/mem_lsu_if.sv
// Data-bus port bundle between the memory-stage LSU (master) and the memory
// system (slave): one request/acknowledge transaction per access.
interface mem_lsu_if;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [3:0]  bus_be;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ack;

   modport master (
      output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      input  bus_rdata, bus_ack
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
      output bus_rdata, bus_ack
   );
endinterface

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: runs one bus transaction per access, aligns and
// extends load data, stalls the pipeline and reports address errors and bus timeouts.
module mem_lsu #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned TO_W    = 8
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        mem_valid,
   input  logic [31:0] mem_alu_result,
   input  logic [31:0] mem_busB,
   input  logic [1:0]  mem_MemWr,
   input  logic [1:0]  mem_MemRead,
   input  logic        mem_LoadSigned,
   mem_lsu_if.master   bus,
   output logic        mem_stall,
   output logic [31:0] ld_data,
   output logic        ld_valid,
   output logic        adel,
   output logic        ades,
   output logic        bus_err,
   output logic [31:0] badvaddr
);

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 32'd1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   state_t      state_r;
   logic [TO_W-1:0] cnt_r;
   logic        bus_req_r;
   logic        bus_we_r;
   logic [31:0] bus_addr_r;
   logic [3:0]  bus_be_r;
   logic [31:0] bus_wdata_r;
   logic [31:0] ld_data_r;
   logic        ld_valid_r;
   logic        adel_r;
   logic        ades_r;
   logic        bus_err_r;
   logic [31:0] badvaddr_r;
   logic        ld_op_r;
   logic [1:0]  ld_size_r;
   logic        ld_signed_r;
   logic [1:0]  lane_r;

   logic        is_store_s;
   logic        is_load_s;
   logic        op_s;
   logic [1:0]  size_s;
   logic        misaligned_s;
   logic [3:0]  be_s;
   logic [31:0] wdata_s;
   logic        mem_stall_s;
   logic [31:0] ld_extract_s;

   // Pick the byte/half lane out of the read word and widen it to 32 bits.
   function automatic logic [31:0] load_extract(
      input logic [31:0] rdata,
      input logic [1:0]  size,
      input logic [1:0]  lane,
      input logic        sgn
   );
      logic [31:0] shifted;
      logic [31:0] result;
      shifted = rdata >> {lane, 3'b000};
      case (size)
         2'b01: result = sgn ? {{24{shifted[7]}}, shifted[7:0]}
                             : {24'h00_0000, shifted[7:0]};
         2'b10: result = sgn ? {{16{shifted[15]}}, shifted[15:0]}
                             : {16'h0000, shifted[15:0]};
         default: result = rdata;
      endcase
      return result;
   endfunction

   // Request decode: a store outranks a load issued in the same slot.
   always_comb begin
      is_store_s   = (mem_MemWr != 2'b00);
      is_load_s    = (mem_MemRead != 2'b00);
      op_s         = mem_valid & (is_store_s | is_load_s);
      size_s       = is_store_s ? mem_MemWr : mem_MemRead;
      misaligned_s = 1'b0;
      be_s         = 4'b0000;
      wdata_s      = 32'h0000_0000;
      mem_stall_s  = 1'b0;

      case (size_s)
         2'b01: begin
            be_s = 4'b0001 << mem_alu_result[1:0];
         end
         2'b10: begin
            misaligned_s = mem_alu_result[0];
            be_s         = mem_alu_result[1] ? 4'b1100 : 4'b0011;
         end
         2'b11: begin
            misaligned_s = (mem_alu_result[1:0] != 2'b00);
            be_s         = 4'b1111;
         end
         default: begin
            misaligned_s = 1'b0;
            be_s         = 4'b0000;
         end
      endcase

      case (mem_MemWr)
         2'b01:   wdata_s = {4{mem_busB[7:0]}};
         2'b10:   wdata_s = {2{mem_busB[15:0]}};
         2'b11:   wdata_s = mem_busB;
         default: wdata_s = 32'h0000_0000;
      endcase

      case (state_r)
         ST_IDLE: mem_stall_s = op_s & ~misaligned_s;
         ST_BUSY: mem_stall_s = 1'b1;
         ST_DONE: mem_stall_s = 1'b0;
         default: mem_stall_s = 1'b0;
      endcase

      ld_extract_s = load_extract(bus.bus_rdata, ld_size_r, lane_r, ld_signed_r);
   end

   // Transaction sequencer with registered bus, load-result and fault outputs.
   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state_r     <= ST_IDLE;
         cnt_r       <= '0;
         bus_req_r   <= 1'b0;
         bus_we_r    <= 1'b0;
         bus_addr_r  <= 32'h0000_0000;
         bus_be_r    <= 4'b0000;
         bus_wdata_r <= 32'h0000_0000;
         ld_data_r   <= 32'h0000_0000;
         ld_valid_r  <= 1'b0;
         adel_r      <= 1'b0;
         ades_r      <= 1'b0;
         bus_err_r   <= 1'b0;
         badvaddr_r  <= 32'h0000_0000;
         ld_op_r     <= 1'b0;
         ld_size_r   <= 2'b00;
         ld_signed_r <= 1'b0;
         lane_r      <= 2'b00;
      end else begin
         case (state_r)
            ST_IDLE: begin
               ld_valid_r <= 1'b0;
               bus_err_r  <= 1'b0;
               if (op_s && misaligned_s) begin
                  adel_r     <= ~is_store_s;
                  ades_r     <= is_store_s;
                  badvaddr_r <= mem_alu_result;
               end else if (op_s) begin
                  adel_r      <= 1'b0;
                  ades_r      <= 1'b0;
                  bus_req_r   <= 1'b1;
                  bus_we_r    <= is_store_s;
                  bus_addr_r  <= {mem_alu_result[31:2], 2'b00};
                  bus_be_r    <= be_s;
                  bus_wdata_r <= wdata_s;
                  ld_op_r     <= ~is_store_s;
                  ld_size_r   <= size_s;
                  ld_signed_r <= mem_LoadSigned;
                  lane_r      <= mem_alu_result[1:0];
                  cnt_r       <= '0;
                  state_r     <= ST_BUSY;
               end else begin
                  adel_r <= 1'b0;
                  ades_r <= 1'b0;
               end
            end
            ST_BUSY: begin
               adel_r <= 1'b0;
               ades_r <= 1'b0;
               if (bus.bus_ack) begin
                  bus_req_r <= 1'b0;
                  if (ld_op_r) begin
                     ld_data_r  <= ld_extract_s;
                     ld_valid_r <= 1'b1;
                  end
                  state_r <= ST_DONE;
               end else if (cnt_r == TO_LAST) begin
                  bus_req_r <= 1'b0;
                  bus_err_r <= 1'b1;
                  ld_data_r <= 32'h0000_0000;
                  state_r   <= ST_DONE;
               end else begin
                  cnt_r <= cnt_r + TO_W'(1);
               end
            end
            ST_DONE: begin
               // The op still sitting in EX/MEM was just serviced; let it leave.
               ld_valid_r <= 1'b0;
               bus_err_r  <= 1'b0;
               adel_r     <= 1'b0;
               ades_r     <= 1'b0;
               state_r    <= ST_IDLE;
            end
            default: begin
               bus_req_r  <= 1'b0;
               ld_valid_r <= 1'b0;
               bus_err_r  <= 1'b0;
               adel_r     <= 1'b0;
               ades_r     <= 1'b0;
               state_r    <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.bus_req   = bus_req_r;
   assign bus.bus_we    = bus_we_r;
   assign bus.bus_addr  = bus_addr_r;
   assign bus.bus_be    = bus_be_r;
   assign bus.bus_wdata = bus_wdata_r;
   assign mem_stall     = mem_stall_s;
   assign ld_data       = ld_data_r;
   assign ld_valid      = ld_valid_r;
   assign adel          = adel_r;
   assign ades          = ades_r;
   assign bus_err       = bus_err_r;
   assign badvaddr      = badvaddr_r;

endmodule
